// File: rtl/up5bit_counter_arbiter.sv
// rtl/up5bit_counter_arbiter.sv - round-robin arbiter sharing one 5-bit interval counter
// Two requesters take turns owning the counter; every output is registered.
module up5bit_counter_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [4:0] limit0,
    input  logic [4:0] limit1,
    output logic       grant0,
    output logic       grant1,
    output logic [4:0] count,
    output logic       done0,
    output logic       done1,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q;
    logic [4:0] count_q;
    logic [4:0] limit_q;
    logic       owner_q;
    logic       last_q;
    logic       grant0_q, grant1_q;
    logic       done0_q, done1_q;
    logic       busy_q;

    logic       winner_d;
    logic       owner_req_d;

    // Contention goes to whoever did not finish the previous interval.
    always_comb begin
        winner_d    = (req0 && req1) ? ~last_q : ~req0;
        owner_req_d = owner_q ? req1 : req0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= 5'd0;
            limit_q  <= 5'd0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            grant0_q <= 1'b0;
            grant1_q <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    count_q <= 5'd0;
                    busy_q  <= 1'b0;
                    if (req0 || req1) begin
                        state_q  <= RUN;
                        owner_q  <= winner_d;
                        grant0_q <= ~winner_d;
                        grant1_q <= winner_d;
                        limit_q  <= winner_d ? limit1 : limit0;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    // A dropped request wins over reaching the limit: no done pulse.
                    if (!owner_req_d) begin
                        state_q  <= IDLE;
                        grant0_q <= 1'b0;
                        grant1_q <= 1'b0;
                        count_q  <= 5'd0;
                        busy_q   <= 1'b0;
                    end else if (count_q == limit_q) begin
                        state_q  <= DONE;
                        grant0_q <= 1'b0;
                        grant1_q <= 1'b0;
                        done0_q  <= ~owner_q;
                        done1_q  <= owner_q;
                        count_q  <= 5'd0;
                        last_q   <= owner_q;
                    end else begin
                        count_q <= count_q + 5'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    grant0_q <= 1'b0;
                    grant1_q <= 1'b0;
                    done0_q  <= 1'b0;
                    done1_q  <= 1'b0;
                    count_q  <= 5'd0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign grant0 = grant0_q;
    assign grant1 = grant1_q;
    assign count  = count_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign busy   = busy_q;
endmodule

// File: tb/tb_up5bit_counter_arbiter.sv
// tb/tb_up5bit_counter_arbiter.sv - directed and random checks of up5bit_counter_arbiter
module tb_up5bit_counter_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [4:0] limit0, limit1;
    logic       grant0, grant1, done0, done1, busy;
    logic [4:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: time since grant (-1 when idle), owner, latched limit, last completed owner.
    int m_t, m_L, m_owner, m_last;

    int   seq[$];
    logic pg0, pg1;
    int   nd0;

    always #5 clk = ~clk;

    up5bit_counter_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .limit0 (limit0),
        .limit1 (limit1),
        .grant0 (grant0),
        .grant1 (grant1),
        .count  (count),
        .done0  (done0),
        .done1  (done1),
        .busy   (busy)
    );

    function automatic logic [9:0] expected();
        logic g0, g1, d0, d1, b;
        logic [4:0] c;
        g0 = 1'b0; g1 = 1'b0; d0 = 1'b0; d1 = 1'b0; b = 1'b0; c = 5'd0;
        if (m_t >= 0 && m_t <= m_L) begin
            b = 1'b1;
            c = m_t[4:0];
            if (m_owner == 0) g0 = 1'b1; else g1 = 1'b1;
        end else if (m_t == m_L + 1) begin
            b = 1'b1;
            if (m_owner == 0) d0 = 1'b1; else d1 = 1'b1;
        end
        return {g0, g1, d0, d1, b, c};
    endfunction

    task automatic model_reset();
        m_t = -1; m_L = 0; m_owner = 0; m_last = 1;
    endtask

    task automatic model_edge();
        if (m_t < 0) begin
            if (req0 || req1) begin
                m_owner = (req0 && req1) ? ((m_last == 0) ? 1 : 0) : (req0 ? 0 : 1);
                m_L     = (m_owner == 0) ? int'(limit0) : int'(limit1);
                m_t     = 0;
            end
        end else if (m_t <= m_L) begin
            if (!((m_owner == 0) ? req0 : req1)) begin
                m_t = -1;
            end else begin
                m_t++;
                if (m_t == m_L + 1) m_last = m_owner;
            end
        end else begin
            m_t = -1;
        end
    endtask

    task automatic check(input string tag);
        logic [9:0] obs, exp;
        obs = {grant0, grant1, done0, done1, busy, count};
        exp = expected();
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        n_checks++;
        assert (!(grant0 && grant1) && !(done0 && done1)) else begin
            n_fail++;
            $error("FAIL %s_exclusive observed=%b%b%b%b expected=no_overlap", tag, grant0, grant1, done0, done1);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        check(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check("reset");
        reset = 1'b0;
    endtask

    initial begin
        req0 = 1'b0; req1 = 1'b0; limit0 = 5'd0; limit1 = 5'd0;
        do_reset();
        chk("reset_busy", busy, 0);

        // Single requester, limit 4.
        req0 = 1'b1; limit0 = 5'd4;
        for (int k = 0; k <= 4; k++) begin
            cycle("t1_run");
            chk("t1_count", count, k);
            chk("t1_grant0", grant0, 1);
        end
        cycle("t1_done");
        chk("t1_done0", done0, 1);
        chk("t1_count0", count, 0);
        req0 = 1'b0;
        cycle("t1_idle");
        chk("t1_busy_low", busy, 0);

        // limit 0: one RUN cycle then done.
        req1 = 1'b1; limit1 = 5'd0;
        cycle("t3_run");
        chk("t3_grant1", grant1, 1);
        chk("t3_count", count, 0);
        cycle("t3_done");
        chk("t3_done1", done1, 1);
        req1 = 1'b0;
        cycle("t3_idle");

        // Round-robin with both requests held.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; limit0 = 5'd2; limit1 = 5'd3;
        pg0 = 1'b0; pg1 = 1'b0; nd0 = 0;
        for (int i = 0; i < 24; i++) begin
            cycle("t2_rr");
            if (grant0 && !pg0) seq.push_back(0);
            if (grant1 && !pg1) seq.push_back(1);
            pg0 = grant0; pg1 = grant1;
            if (done0) nd0++;
        end
        chk("t2_ngrants", (seq.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++)
            chk("t2_order", (i < seq.size()) ? seq[i] : -1, i % 2);
        chk("t2_done0_count", nd0, 2);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) cycle("t2_drain");

        // Abort at count 10 does not change the round-robin history.
        do_reset();
        req0 = 1'b1; limit0 = 5'd31;
        cycle("t4_grant");
        repeat (10) cycle("t4_run");
        chk("t4_count10", count, 10);
        req0 = 1'b0;
        cycle("t4_abort");
        chk("t4_grant0_low", grant0, 0);
        chk("t4_done0_none", done0, 0);
        chk("t4_count0", count, 0);
        req0 = 1'b1; req1 = 1'b1; limit0 = 5'd1; limit1 = 5'd1;
        cycle("t4_contend");
        chk("t4_favour0", grant0, 1);
        repeat (2) cycle("t4_finish");
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) cycle("t4_drain");

        // Asynchronous reset in the middle of a requester 1 interval.
        do_reset();
        req1 = 1'b1; limit1 = 5'd20;
        cycle("t5_grant");
        repeat (7) cycle("t5_run");
        chk("t5_count7", count, 7);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("t5_async");
        chk("t5_async_count", count, 0);
        req0 = 1'b1; req1 = 1'b1; limit0 = 5'd3;
        @(negedge clk);
        reset = 1'b0;
        cycle("t5_resume");
        chk("t5_grant0_first", grant0, 1);
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) cycle("t5_drain");

        // Limit change while running is ignored.
        req0 = 1'b1; limit0 = 5'd5;
        cycle("t6_grant");
        limit0 = 5'd1;
        repeat (5) cycle("t6_run");
        chk("t6_count5", count, 5);
        cycle("t6_done");
        chk("t6_done0", done0, 1);
        req0 = 1'b0;
        cycle("t6_idle");

        // Random traffic against the reference.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                req0   = ($urandom_range(0, 9) < 7);
                req1   = ($urandom_range(0, 9) < 7);
                limit0 = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
                limit1 = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
                cycle("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
